// File: rtl/key_debounce_pulse.sv
// ----------------------------------------------------------------------------
// key_debounce_pulse
//   Conditions the board push-buttons before they reach the control FSM.
//   Each raw active-low button is brought into the clk domain with a two-flop
//   synchroniser and then debounced by its own four-state channel FSM. Each
//   channel emits one-cycle press, release and long-press events.
//
// Ports
//   clk          in   1       system clock
//   rst_n        in   1       asynchronous reset, active-low
//   key_raw_n    in   N_KEYS  raw button pins, active-low, asynchronous, bouncing
//   key_level_n  out  N_KEYS  debounced button level, active-low
//   key_press_n  out  N_KEYS  one-cycle active-low pulse on a confirmed press
//   key_release  out  N_KEYS  one-cycle active-high pulse on a confirmed release
//   key_long     out  N_KEYS  one-cycle pulse, HOLD_CYCLES after press confirmation
//   any_press    out  1       high in the same cycle as any key_press_n bit is low
// ----------------------------------------------------------------------------
module key_debounce_pulse #(
    parameter int N_KEYS      = 4,
    parameter int DB_CYCLES   = 2_000_000,   // >= 2
    parameter int HOLD_CYCLES = 100_000_000  // >= 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw_n,
    output logic [N_KEYS-1:0] key_level_n,
    output logic [N_KEYS-1:0] key_press_n,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              any_press
);

    localparam int MAX_CYC = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchroniser. Reset to 1 so that a reset looks like
    // "nothing pressed" to the channels.
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] sync_1;
    logic [N_KEYS-1:0] sync_s;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample the pre-edge value and the chain really is two flops deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '1;
            sync_s <= '1;
        end else begin
            sync_1 <= key_raw_n;
            sync_s <= sync_1;
        end
    end

    // Per-channel next-cycle press pulse, gathered so any_press can be
    // registered in step with key_press_n.
    logic [N_KEYS-1:0] press_next_n;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] db_q, db_d;
        logic [CNT_W-1:0] hold_q, hold_d;
        logic             fired_q, fired_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             rel_q, rel_d;
        logic             long_q, long_d;
        logic             s;

        assign s = sync_s[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                db_q    <= '0;
                hold_q  <= '0;
                fired_q <= 1'b0;
                level_q <= 1'b1;
                press_q <= 1'b1;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                db_q    <= db_d;
                hold_q  <= hold_d;
                fired_q <= fired_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
            end
        end

        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            db_d    = db_q;
            hold_d  = hold_q;
            fired_d = fired_q;
            level_d = level_q;
            press_d = 1'b1;
            rel_d   = 1'b0;
            long_d  = 1'b0;

            case (state_q)
                IDLE: begin
                    if (!s) begin
                        state_d = PRESS_WAIT;
                        db_d    = CNT_ONE;
                    end
                end

                PRESS_WAIT: begin
                    if (s) begin
                        state_d = IDLE;
                        db_d    = '0;
                    end else if (db_q == DB_LAST) begin
                        state_d = PRESSED;
                        db_d    = '0;
                        press_d = 1'b0;
                        level_d = 1'b0;
                        hold_d  = '0;
                        fired_d = 1'b0;
                    end else begin
                        db_d = db_q + CNT_ONE;
                    end
                end

                PRESSED, RELEASE_WAIT: begin
                    if (!s) begin
                        // Held low: stay (or return) to PRESSED and advance
                        // the hold counter. The counter saturates at its last
                        // value; the long pulse is issued on the next held
                        // sample, which lands it HOLD_CYCLES cycles after the
                        // press pulse. fired_q keeps it to once per press.
                        state_d = PRESSED;
                        db_d    = '0;
                        if (hold_q != HOLD_LAST) begin
                            hold_d = hold_q + CNT_ONE;
                        end else if (!fired_q) begin
                            long_d  = 1'b1;
                            fired_d = 1'b1;
                        end
                    end else if (state_q == PRESSED) begin
                        // First high sample: start release debounce, hold
                        // counter stays frozen.
                        state_d = RELEASE_WAIT;
                        db_d    = CNT_ONE;
                    end else if (db_q == DB_LAST) begin
                        state_d = IDLE;
                        db_d    = '0;
                        rel_d   = 1'b1;
                        level_d = 1'b1;
                    end else begin
                        db_d = db_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    db_d    = '0;
                end
            endcase
        end

        assign key_level_n[i]  = level_q;
        assign key_press_n[i]  = press_q;
        assign key_release[i]  = rel_q;
        assign key_long[i]     = long_q;
        assign press_next_n[i] = press_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press <= 1'b0;
        end else begin
            any_press <= ~&press_next_n;
        end
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// ----------------------------------------------------------------------------
// tb_key_debounce_pulse
//   Directed bench for key_debounce_pulse with DB_CYCLES=4, HOLD_CYCLES=10.
//   A run-length model (debounced level flips after DB consecutive disagreeing
//   samples; long fires on the HOLD-th held sample after confirmation) is
//   compared with the DUT every cycle. Every cycle's outputs are also logged
//   so the directed scenarios can pin exact pulse timing with literal values.
// ----------------------------------------------------------------------------
module tb_key_debounce_pulse;

    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int HN   = 1024;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key_raw_n = '0;
    logic [N-1:0] key_level_n;
    logic [N-1:0] key_press_n;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;
    logic         any_press;

    always #5 clk = ~clk;

    key_debounce_pulse #(
        .N_KEYS      (N),
        .DB_CYCLES   (DB),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_raw_n   (key_raw_n),
        .key_level_n (key_level_n),
        .key_press_n (key_press_n),
        .key_release (key_release),
        .key_long    (key_long),
        .any_press   (any_press)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_s1, m_s2, m_lvl, m_press_n, m_rel, m_long;
    logic         m_any;
    int           m_run  [N];
    int           m_hold [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1      = '1;
            m_s2      = '1;
            m_lvl     = '1;
            m_press_n = '1;
            m_rel     = '0;
            m_long    = '0;
            m_any     = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_run[i]  = 0;
                m_hold[i] = 0;
            end
        end else begin
            m_press_n = '1;
            m_rel     = '0;
            m_long    = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_s2[i] == 1'b0) begin
                            m_press_n[i] = 1'b0;
                            m_hold[i]    = 0;
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                    if (!m_lvl[i] && m_hold[i] < HOLD) begin
                        m_hold[i]++;
                        if (m_hold[i] == HOLD) m_long[i] = 1'b1;
                    end
                end
            end
            m_any = (m_press_n != '1);
            m_s2  = m_s1;
            m_s1  = key_raw_n;
        end
    end

    // ---------------- per-cycle compare and history ----------------
    logic [N-1:0] h_press [HN];
    logic [N-1:0] h_rel   [HN];
    logic [N-1:0] h_long  [HN];
    logic [N-1:0] h_level [HN];
    logic         h_any   [HN];
    logic [N-1:0] h_mpress[HN];
    logic [N-1:0] h_mlong [HN];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (cyc < HN) begin
            h_press[cyc]  = key_press_n;
            h_rel[cyc]    = key_release;
            h_long[cyc]   = key_long;
            h_level[cyc]  = key_level_n;
            h_any[cyc]    = any_press;
            h_mpress[cyc] = m_press_n;
            h_mlong[cyc]  = m_long;
        end
        check("cmp key_level_n", 32'(key_level_n), 32'(m_lvl));
        check("cmp key_press_n", 32'(key_press_n), 32'(m_press_n));
        check("cmp key_release", 32'(key_release), 32'(m_rel));
        check("cmp key_long",    32'(key_long),    32'(m_long));
        check("cmp any_press",   32'(any_press),   32'(m_any));
    end

    // Count logged cycles in [a,b] with an event on key k.
    // sel: 0 press, 1 release, 2 long, 3 level low.
    function automatic int n_evt(input int sel, input int k, input int a, input int b);
        int n = 0;
        for (int c = a; c <= b && c < HN; c++) begin
            case (sel)
                0: if (!h_press[c][k]) n++;
                1: if (h_rel[c][k])    n++;
                2: if (h_long[c][k])   n++;
                default: if (!h_level[c][k]) n++;
            endcase
        end
        return n;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int t0, t1, rc, st;

    initial begin
        // 1. Reset with all keys held
        rst_n     = 1'b0;
        key_raw_n = 4'b0000;
        step(3);
        rc = cyc;
        check("rst level_n", 32'(h_level[rc]), 32'hF);
        check("rst press_n", 32'(h_press[rc]), 32'hF);
        check("rst release", 32'(h_rel[rc]),   32'h0);
        check("rst long",    32'(h_long[rc]),  32'h0);
        check("rst any",     32'(h_any[rc]),   32'h0);
        rst_n = 1'b1;
        t0 = cyc;
        step(8);
        check("t1 press before", 32'(h_press[t0+5]), 32'hF);
        check("t1 press at 6",   32'(h_press[t0+6]), 32'h0);
        check("t1 any at 6",     32'(h_any[t0+6]),   32'h1);
        check("t1 press after",  32'(h_press[t0+7]), 32'hF);
        check("t1 model pin",    32'(h_mpress[t0+6]), 32'h0);
        key_raw_n = 4'b1111;
        t1 = cyc;
        step(10);
        check("t1 release at 6", 32'(h_rel[t1+6]),   32'hF);
        check("t1 level at 5",   32'(h_level[t1+5]), 32'h0);
        check("t1 level at 6",   32'(h_level[t1+6]), 32'hF);

        // 2. Bounce on press, key 0
        st = cyc;
        key_raw_n = 4'b1110; step(1);
        key_raw_n = 4'b1111; step(1);
        key_raw_n = 4'b1110; step(1);
        key_raw_n = 4'b1111; step(1);
        key_raw_n = 4'b1110;
        t0 = cyc;
        step(10);
        check("t2 press count",  n_evt(0, 0, st, t0+9), 1);
        check("t2 press at 6",   32'(h_press[t0+6][0]), 32'h0);
        check("t2 level at 6",   32'(h_level[t0+6][0]), 32'h0);
        key_raw_n = 4'b1111;
        t1 = cyc;
        step(10);
        check("t2 release count", n_evt(1, 0, t1, t1+9), 1);
        check("t2 release at 6",  32'(h_rel[t1+6][0]), 32'h1);

        // 3. Long press, key 2
        key_raw_n = 4'b1011;
        t0 = cyc;
        step(30);
        key_raw_n = 4'b1111;
        t1 = cyc;
        step(10);
        check("t3 press at 6",    32'(h_press[t0+6][2]), 32'h0);
        check("t3 long at 16",    32'(h_long[t0+16][2]), 32'h1);
        check("t3 long model",    32'(h_mlong[t0+16][2]), 32'h1);
        check("t3 long count",    n_evt(2, 2, t0, t1+9), 1);
        check("t3 release at 6",  32'(h_rel[t1+6][2]), 32'h1);
        check("t3 release count", n_evt(1, 2, t0, t1+9), 1);
        check("t3 level held",    n_evt(3, 2, t0, t1+9), 30);

        // 4. Short glitch, key 1
        key_raw_n = 4'b1101;
        t0 = cyc;
        step(3);
        key_raw_n = 4'b1111;
        step(12);
        check("t4 no press",   n_evt(0, 1, t0, t0+14), 0);
        check("t4 no release", n_evt(1, 1, t0, t0+14), 0);
        check("t4 no long",    n_evt(2, 1, t0, t0+14), 0);
        check("t4 level high", n_evt(3, 1, t0, t0+14), 0);

        // 5. Simultaneous keys 0 and 3
        key_raw_n = 4'b0110;
        t0 = cyc;
        step(8);
        check("t5 press at 6",  32'(h_press[t0+6]), 32'h6);
        check("t5 any at 6",    32'(h_any[t0+6]),   32'h1);
        check("t5 any at 5",    32'(h_any[t0+5]),   32'h0);
        check("t5 press at 7",  32'(h_press[t0+7]), 32'hF);
        key_raw_n = 4'b1111;
        step(10);

        // 6. Reset mid-hold, key 3 (hold count 5 after edge t0+11)
        key_raw_n = 4'b0111;
        t0 = cyc;
        step(11);
        rst_n     = 1'b0;
        key_raw_n = 4'b1111;
        check("t6 press at 6", 32'(h_press[t0+6][3]), 32'h0);
        step(3);
        rc = cyc;
        check("t6 rst level_n", 32'(h_level[rc]), 32'hF);
        check("t6 rst press_n", 32'(h_press[rc]), 32'hF);
        check("t6 rst long",    32'(h_long[rc]),  32'h0);
        check("t6 rst release", 32'(h_rel[rc]),   32'h0);
        rst_n = 1'b1;
        t1 = cyc;
        step(20);
        check("t6 no long",    n_evt(2, 3, t0, t1+19), 0);
        check("t6 no release", n_evt(1, 3, t0, t1+19), 0);
        check("t6 level end",  32'(h_level[t1+19]), 32'hF);
        check("t6 press end",  32'(h_press[t1+19]), 32'hF);
        check("t6 any end",    32'(h_any[t1+19]),   32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
